// File: rtl/nbody_step_sequencer.sv
// nbody_step_sequencer: per-step pair issue, velocity write-back tagging and
// position-update sweep for the N-body accelerator, plus the software go/done/ack
// handshake and RAM-ownership select.
module nbody_step_sequencer #(
    parameter int unsigned BODIES          = 512,
    parameter int unsigned BODY_ADDR_WIDTH = $clog2(BODIES),
    parameter int unsigned ACCEL_LAT       = 122,
    parameter int unsigned UPDATE_LAT      = 20,
    parameter int unsigned STEP_WIDTH      = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       go,
    input  logic                       ack,
    input  logic [BODY_ADDR_WIDTH:0]   num_bodies,
    input  logic [STEP_WIDTH-1:0]      num_steps,
    output logic                       busy,
    output logic                       done,
    output logic                       aborted,
    output logic                       sw_own,
    output logic [STEP_WIDTH-1:0]      steps_done,
    output logic                       pair_valid,
    output logic [BODY_ADDR_WIDTH-1:0] pair_i,
    output logic [BODY_ADDR_WIDTH-1:0] pair_j,
    output logic                       pair_self,
    output logic                       pair_last,
    output logic                       acc_wr_valid,
    output logic [BODY_ADDR_WIDTH-1:0] acc_wr_idx,
    output logic                       upd_rd_valid,
    output logic [BODY_ADDR_WIDTH-1:0] upd_rd_idx,
    output logic                       upd_wr_valid,
    output logic [BODY_ADDR_WIDTH-1:0] upd_wr_idx
);
    localparam int unsigned BW      = BODY_ADDR_WIDTH;
    localparam int unsigned UPD_DLY = UPDATE_LAT + 1;
    localparam logic [BW:0] MAX_N   = (BW+1)'(BODIES);

    typedef enum logic [2:0] {
        IDLE, ACCEL, ACCEL_DRAIN, UPDATE, UPDATE_DRAIN, DONE
    } state_t;

    state_t                        state_q, state_d, out_state_c;
    logic                          go_q;
    logic [BW:0]                   n_q;
    logic [STEP_WIDTH-1:0]         s_q, steps_d;
    logic [BW-1:0]                 i_q, i_d, j_q, j_d, k_q, k_d, last_idx_c;
    logic                          start_c, abort_c, run_state_c, out_busy_c;
    logic [ACCEL_LAT-1:0]          acc_v_sr;
    logic [ACCEL_LAT-1:0][BW-1:0]  acc_idx_sr;
    logic [UPD_DLY-1:0]            upd_v_sr;
    logic [UPD_DLY-1:0][BW-1:0]    upd_idx_sr;

    assign last_idx_c  = BW'(n_q - (BW+1)'(1));
    assign run_state_c = state_q inside {ACCEL, ACCEL_DRAIN, UPDATE, UPDATE_DRAIN};
    assign out_state_c = abort_c ? IDLE : state_q;
    assign out_busy_c  = run_state_c & ~abort_c;

    // Next-state, index counters and step counter.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        steps_d = steps_done;
        start_c = 1'b0;
        abort_c = 1'b0;
        if (run_state_c && !go) begin
            abort_c = 1'b1;
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (go && !go_q) begin
                        start_c = 1'b1;
                        i_d     = '0;
                        j_d     = '0;
                        k_d     = '0;
                        steps_d = '0;
                        state_d = (num_bodies == '0 || num_steps == '0) ? DONE : ACCEL;
                    end
                end
                ACCEL: begin
                    if (j_q == last_idx_c) begin
                        j_d = '0;
                        if (i_q == last_idx_c) begin
                            i_d     = '0;
                            state_d = ACCEL_DRAIN;
                        end else begin
                            i_d = i_q + BW'(1);
                        end
                    end else begin
                        j_d = j_q + BW'(1);
                    end
                end
                ACCEL_DRAIN: begin
                    if (acc_wr_valid && acc_wr_idx == last_idx_c) begin
                        state_d = UPDATE;
                    end
                end
                UPDATE: begin
                    if (k_q == last_idx_c) begin
                        k_d     = '0;
                        state_d = UPDATE_DRAIN;
                    end else begin
                        k_d = k_q + BW'(1);
                    end
                end
                UPDATE_DRAIN: begin
                    if (upd_wr_valid && upd_wr_idx == last_idx_c) begin
                        steps_d = (steps_done == '1) ? steps_done : steps_done + STEP_WIDTH'(1);
                        state_d = (steps_d == s_q) ? DONE : ACCEL;
                    end
                end
                DONE: begin
                    if (ack) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State, counters and latched run configuration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            go_q       <= 1'b0;
            n_q        <= '0;
            s_q        <= '0;
            i_q        <= '0;
            j_q        <= '0;
            k_q        <= '0;
            steps_done <= '0;
            aborted    <= 1'b0;
        end else begin
            state_q    <= state_d;
            go_q       <= go;
            i_q        <= i_d;
            j_q        <= j_d;
            k_q        <= k_d;
            steps_done <= steps_d;
            if (start_c) begin
                n_q     <= (num_bodies > MAX_N) ? MAX_N : num_bodies;
                s_q     <= num_steps;
                aborted <= 1'b0;
            end
            if (abort_c) begin
                aborted <= 1'b1;
            end
        end
    end

    // Registered status and issue outputs; an abort forces idle values at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy         <= 1'b0;
            sw_own       <= 1'b1;
            done         <= 1'b0;
            pair_valid   <= 1'b0;
            pair_i       <= '0;
            pair_j       <= '0;
            pair_self    <= 1'b0;
            pair_last    <= 1'b0;
            upd_rd_valid <= 1'b0;
            upd_rd_idx   <= '0;
        end else begin
            busy         <= out_busy_c;
            sw_own       <= ~out_busy_c;
            done         <= (out_state_c == DONE);
            pair_valid   <= (out_state_c == ACCEL);
            pair_i       <= (out_state_c == ACCEL) ? i_q : '0;
            pair_j       <= (out_state_c == ACCEL) ? j_q : '0;
            pair_self    <= (out_state_c == ACCEL) && (i_q == j_q);
            pair_last    <= (out_state_c == ACCEL) && (j_q == last_idx_c);
            upd_rd_valid <= (out_state_c == UPDATE);
            upd_rd_idx   <= (out_state_c == UPDATE) ? k_q : '0;
        end
    end

    // Write-back tag pipelines matching the datapath latencies; flushed on abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_v_sr   <= '0;
            acc_idx_sr <= '0;
            upd_v_sr   <= '0;
            upd_idx_sr <= '0;
        end else if (abort_c) begin
            acc_v_sr   <= '0;
            acc_idx_sr <= '0;
            upd_v_sr   <= '0;
            upd_idx_sr <= '0;
        end else begin
            acc_v_sr[0]   <= pair_valid & pair_last;
            acc_idx_sr[0] <= pair_i;
            for (int k = 1; k < int'(ACCEL_LAT); k++) begin
                acc_v_sr[k]   <= acc_v_sr[k-1];
                acc_idx_sr[k] <= acc_idx_sr[k-1];
            end
            upd_v_sr[0]   <= upd_rd_valid;
            upd_idx_sr[0] <= upd_rd_idx;
            for (int k = 1; k < int'(UPD_DLY); k++) begin
                upd_v_sr[k]   <= upd_v_sr[k-1];
                upd_idx_sr[k] <= upd_idx_sr[k-1];
            end
        end
    end

    assign acc_wr_valid = acc_v_sr[ACCEL_LAT-1];
    assign acc_wr_idx   = acc_idx_sr[ACCEL_LAT-1];
    assign upd_wr_valid = upd_v_sr[UPD_DLY-1];
    assign upd_wr_idx   = upd_idx_sr[UPD_DLY-1];

endmodule

// File: tb/tb_nbody_step_sequencer.sv
// Testbench for nbody_step_sequencer: per-cycle comparison against a timeline
// model built from step-level arithmetic.
module tb_nbody_step_sequencer;
    localparam int unsigned BODIES = 8;
    localparam int unsigned BW     = $clog2(BODIES);
    localparam int unsigned A      = 4;
    localparam int unsigned U      = 2;
    localparam int unsigned SW     = 32;

    typedef struct packed {
        logic          busy;
        logic          done;
        logic          aborted;
        logic          sw_own;
        logic [SW-1:0] steps;
        logic          pv;
        logic [BW-1:0] pi;
        logic [BW-1:0] pj;
        logic          ps;
        logic          pl;
        logic          av;
        logic [BW-1:0] ai;
        logic          rv;
        logic [BW-1:0] ri;
        logic          wv;
        logic [BW-1:0] wi;
    } obs_t;

    logic          clk, rst, go, ack;
    logic [BW:0]   num_bodies;
    logic [SW-1:0] num_steps;
    logic          busy, done, aborted, sw_own;
    logic [SW-1:0] steps_done;
    logic          pair_valid, pair_self, pair_last;
    logic [BW-1:0] pair_i, pair_j;
    logic          acc_wr_valid, upd_rd_valid, upd_wr_valid;
    logic [BW-1:0] acc_wr_idx, upd_rd_idx, upd_wr_idx;

    int n_cmp = 0;
    int n_bad = 0;

    nbody_step_sequencer #(
        .BODIES(BODIES), .BODY_ADDR_WIDTH(BW), .ACCEL_LAT(A),
        .UPDATE_LAT(U), .STEP_WIDTH(SW)
    ) dut (
        .clk(clk), .rst(rst), .go(go), .ack(ack),
        .num_bodies(num_bodies), .num_steps(num_steps),
        .busy(busy), .done(done), .aborted(aborted), .sw_own(sw_own),
        .steps_done(steps_done),
        .pair_valid(pair_valid), .pair_i(pair_i), .pair_j(pair_j),
        .pair_self(pair_self), .pair_last(pair_last),
        .acc_wr_valid(acc_wr_valid), .acc_wr_idx(acc_wr_idx),
        .upd_rd_valid(upd_rd_valid), .upd_rd_idx(upd_rd_idx),
        .upd_wr_valid(upd_wr_valid), .upd_wr_idx(upd_wr_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Total busy cycles of a run; zero when the run completes immediately.
    function automatic int run_len(input int n, input int s);
        int per;
        per = n * n + int'(A) + n + int'(U) + 3;
        return (n == 0 || s == 0) ? 0 : s * per;
    endfunction

    // Expected outputs t cycles after the first pair would appear (t=-1: start edge).
    function automatic obs_t model(input int n, input int s, input int t, input logic ab);
        obs_t e;
        int per, total, o, st, q, r;
        e = '0;
        e.sw_own  = 1'b1;
        e.aborted = ab;
        if (t < 0) return e;
        per   = n * n + int'(A) + n + int'(U) + 3;
        total = run_len(n, s);
        if (t >= total) begin
            e.done  = 1'b1;
            e.steps = (total == 0) ? '0 : SW'(s);
            return e;
        end
        e.busy   = 1'b1;
        e.sw_own = 1'b0;
        st = t / per;
        o  = t % per;
        e.steps = SW'(st + ((o == per - 1) ? 1 : 0));
        if (o < n * n) begin
            e.pv = 1'b1;
            e.pi = BW'(o / n);
            e.pj = BW'(o % n);
            e.ps = ((o / n) == (o % n));
            e.pl = ((o % n) == n - 1);
        end
        q = o - int'(A);
        if (q >= 0 && q < n * n && (q % n) == n - 1) begin
            e.av = 1'b1;
            e.ai = BW'(q / n);
        end
        r = o - (n * n + int'(A) + 1);
        if (r >= 0 && r < n) begin
            e.rv = 1'b1;
            e.ri = BW'(r);
        end
        r = o - (n * n + int'(A) + int'(U) + 2);
        if (r >= 0 && r < n) begin
            e.wv = 1'b1;
            e.wi = BW'(r);
        end
        return e;
    endfunction

    // Snapshot of DUT outputs with payloads hidden while their valid is low.
    function automatic obs_t observe();
        obs_t o;
        o = '0;
        o.busy = busy; o.done = done; o.aborted = aborted; o.sw_own = sw_own;
        o.steps = steps_done;
        o.pv = pair_valid;
        if (pair_valid) begin
            o.pi = pair_i; o.pj = pair_j; o.ps = pair_self; o.pl = pair_last;
        end
        o.av = acc_wr_valid;
        if (acc_wr_valid) o.ai = acc_wr_idx;
        o.rv = upd_rd_valid;
        if (upd_rd_valid) o.ri = upd_rd_idx;
        o.wv = upd_wr_valid;
        if (upd_wr_valid) o.wi = upd_wr_idx;
        return o;
    endfunction

    function automatic obs_t observe_raw();
        obs_t o;
        o = {busy, done, aborted, sw_own, steps_done, pair_valid, pair_i, pair_j,
             pair_self, pair_last, acc_wr_valid, acc_wr_idx, upd_rd_valid,
             upd_rd_idx, upd_wr_valid, upd_wr_idx};
        return o;
    endfunction

    task automatic start_run(input int n, input int s);
        @(negedge clk);
        go = 1'b0;
        ack = 1'b0;
        @(negedge clk);
        num_bodies = (BW+1)'(n);
        num_steps  = SW'(s);
        go = 1'b1;
    endtask

    task automatic ack_pulse(input logic keep_go);
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        go  = keep_go;
    endtask

    task automatic test_reset();
        obs_t got, want;
        want = '0;
        want.sw_own = 1'b1;
        repeat (2) @(negedge clk);
        got = observe_raw();
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL reset_held got=%h want=%h", got, want);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        got = observe_raw();
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL reset_released got=%h want=%h", got, want);
        end
    endtask

    task automatic test_single();
        obs_t got, want;
        start_run(2, 1);
        for (int t = -1; t <= run_len(2, 1) + 1; t++) begin
            @(negedge clk);
            got = observe();
            want = model(2, 1, t, 1'b0);
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL single t=%0d got=%h want=%h", t, got, want);
            end
        end
        ack_pulse(1'b0);
        @(negedge clk);
        got = observe();
        want = model(2, 1, -1, 1'b0);
        want.steps = SW'(1);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL single_ack got=%h want=%h", got, want);
        end
    endtask

    task automatic test_multi_step();
        obs_t got, want;
        int done_rises;
        logic done_prev;
        done_rises = 0;
        done_prev  = 1'b0;
        start_run(3, 3);
        for (int t = -1; t <= run_len(3, 3) + 1; t++) begin
            @(negedge clk);
            if (done && !done_prev) done_rises++;
            done_prev = done;
            got = observe();
            want = model(3, 3, t, 1'b0);
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL multi t=%0d got=%h want=%h", t, got, want);
            end
        end
        n_cmp++;
        if (done_rises !== 1) begin
            n_bad++;
            $display("FAIL multi_done_once got=%0d want=1", done_rises);
        end
        ack_pulse(1'b0);
        @(negedge clk);
    endtask

    task automatic test_max_bodies();
        obs_t got, want;
        int n;
        n = int'(BODIES);
        start_run(n, 1);
        for (int t = -1; t <= run_len(n, 1) + 1; t++) begin
            @(negedge clk);
            got = observe();
            want = model(n, 1, t, 1'b0);
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL max_bodies t=%0d got=%h want=%h", t, got, want);
            end
        end
        ack_pulse(1'b0);
        @(negedge clk);
    endtask

    task automatic test_random_config();
        obs_t got, want;
        int n, s;
        for (int r = 0; r < 6; r++) begin
            n = int'($urandom_range(1, BODIES));
            s = int'($urandom_range(1, 3));
            start_run(n, s);
            for (int t = -1; t <= run_len(n, s) + 1; t++) begin
                @(negedge clk);
                got = observe();
                want = model(n, s, t, 1'b0);
                n_cmp++;
                if (got !== want) begin
                    n_bad++;
                    $display("FAIL random run=%0d n=%0d s=%0d t=%0d got=%h want=%h",
                             r, n, s, t, got, want);
                end
                num_bodies = (BW+1)'($urandom_range(0, BODIES));
                num_steps  = $urandom;
            end
            ack_pulse(1'b0);
            @(negedge clk);
            got = observe();
            want = model(n, s, -1, 1'b0);
            want.steps = SW'(s);
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL random_ack run=%0d got=%h want=%h", r, got, want);
            end
        end
    endtask

    task automatic test_zero_config();
        obs_t got, want;
        int ns [2];
        int ss [2];
        ns[0] = 0; ss[0] = 2;
        ns[1] = 3; ss[1] = 0;
        for (int c = 0; c < 2; c++) begin
            start_run(ns[c], ss[c]);
            for (int t = -1; t <= 2; t++) begin
                @(negedge clk);
                got = observe();
                want = model(ns[c], ss[c], t, 1'b0);
                n_cmp++;
                if (got !== want) begin
                    n_bad++;
                    $display("FAIL zero case=%0d t=%0d got=%h want=%h", c, t, got, want);
                end
            end
            ack_pulse(1'b0);
            @(negedge clk);
        end
    endtask

    task automatic test_abort();
        obs_t got, want;
        start_run(3, 2);
        for (int t = -1; t <= 4; t++) begin
            @(negedge clk);
            got = observe();
            want = model(3, 2, t, 1'b0);
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL abort_pre t=%0d got=%h want=%h", t, got, want);
            end
        end
        go = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            got = observe();
            want = model(3, 2, -1, 1'b1);
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL abort_post k=%0d got=%h want=%h", k, got, want);
            end
            ack = (k == 1);
        end
        ack = 1'b0;
    endtask

    task automatic test_handshake();
        obs_t got, want;
        start_run(1, 1);
        for (int t = -1; t <= run_len(1, 1) + 1; t++) begin
            @(negedge clk);
            got = observe();
            want = model(1, 1, t, 1'b0);
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL hs_run t=%0d got=%h want=%h", t, got, want);
            end
        end
        ack_pulse(1'b1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            got = observe();
            want = model(1, 1, -1, 1'b0);
            want.steps = SW'(1);
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL hs_no_restart k=%0d got=%h want=%h", k, got, want);
            end
        end
        start_run(1, 1);
        for (int t = -1; t <= run_len(1, 1) + 1; t++) begin
            @(negedge clk);
            got = observe();
            want = model(1, 1, t, 1'b0);
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL hs_rerun t=%0d got=%h want=%h", t, got, want);
            end
        end
        ack_pulse(1'b0);
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        obs_t got, want;
        start_run(2, 1);
        for (int t = -1; t <= 2; t++) begin
            @(negedge clk);
            got = observe();
            want = model(2, 1, t, 1'b0);
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL arst_pre t=%0d got=%h want=%h", t, got, want);
            end
        end
        #2;
        rst = 1'b1;
        #1;
        got = observe_raw();
        want = '0;
        want.sw_own = 1'b1;
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL arst_immediate got=%h want=%h", got, want);
        end
        go = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        test_single();
    endtask

    initial begin
        rst = 1'b1;
        go = 1'b0;
        ack = 1'b0;
        num_bodies = '0;
        num_steps = '0;
        test_reset();
        test_single();
        test_multi_step();
        test_max_bodies();
        test_zero_config();
        test_abort();
        test_handshake();
        test_random_config();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
